// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_CNT_W      = $clog2(DIV_DATA_WIDTH);

  localparam logic [DIV_DATA_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_seq_if.sv
// Start/busy/done handshake bundle between the ALU and the divider.
// The div_zero flag exists only when DIV_ZERO_DETECT_EN is defined.
interface div_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  sign;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] r;
`ifdef DIV_ZERO_DETECT_EN
  logic                  div_zero;
`endif

  modport master (
    output start, sign, a, b,
    input  busy, done, q, r
`ifdef DIV_ZERO_DETECT_EN
    , input div_zero
`endif
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, q, r
`ifdef DIV_ZERO_DETECT_EN
    , output div_zero
`endif
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, subtract the
// divisor magnitude if it fits, and shift the resulting quotient bit in.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH:0]   ext_rem;
  logic [DATA_WIDTH-1:0] diff;
  logic                  fits;

  always_comb begin
    ext_rem = {rem_i, quo_i[DATA_WIDTH-1]};
    fits    = ext_rem >= {1'b0, divisor_i};
    // When the divisor fits the true difference is below the divisor, so the
    // modular low-word subtraction is exact.
    diff    = ext_rem[DATA_WIDTH-1:0] - divisor_i;
    rem_o   = fits ? diff : ext_rem[DATA_WIDTH-1:0];
    quo_o   = {quo_i[DATA_WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU (q -> LO, r -> HI).
// Optional DIV_ZERO_DETECT_EN: zero divisors finish in one cycle and flag div_zero.
module div_seq
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH == DIV_DATA_WIDTH) ? DIV_CNT_W : $clog2(DATA_WIDTH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [DATA_WIDTH-1:0] ZERO_Q    = {DATA_WIDTH{DIV_ZERO_Q[0]}};
  localparam logic [CNT_W-1:0]      CNT_START = CNT_W'(DATA_WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] a_raw_q, a_raw_d;
  logic [DATA_WIDTH-1:0] abs_b_q, abs_b_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  b_zero_q, b_zero_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;
`ifdef DIV_ZERO_DETECT_EN
  logic                  div_zero_q, div_zero_d;
`endif

  logic [DATA_WIDTH-1:0] step_rem;
  logic [DATA_WIDTH-1:0] step_quo;
  logic                  accept;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] abs_a;
  logic [DATA_WIDTH-1:0] abs_b;

  div_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (abs_b_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    a_neg  = bus.sign & bus.a[DATA_WIDTH-1];
    b_neg  = bus.sign & bus.b[DATA_WIDTH-1];
    abs_a  = a_neg ? -bus.a : bus.a;
    abs_b  = b_neg ? -bus.b : bus.b;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    a_raw_d    = a_raw_q;
    abs_b_d    = abs_b_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    b_zero_d   = b_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    q_d        = q_q;
    r_d        = r_q;
`ifdef DIV_ZERO_DETECT_EN
    div_zero_d = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (accept) begin
          a_raw_d   = bus.a;
          abs_b_d   = abs_b;
          quo_d     = abs_a;
          rem_d     = '0;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          b_zero_d  = (bus.b == '0);
          cnt_d     = CNT_START;
          state_d   = S_CALC;
          busy_d    = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          if (bus.b == '0) begin
            state_d    = S_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            q_d        = ZERO_Q;
            r_d        = bus.a;
            div_zero_d = 1'b1;
          end
`endif
        end
      end

      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Zero divisor returns the raw dividend with no sign correction.
          if (b_zero_q) begin
            q_d = ZERO_Q;
            r_d = a_raw_q;
          end else begin
            q_d = neg_quo_q ? -step_quo : step_quo;
            r_d = neg_rem_q ? -step_rem : step_rem;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      a_raw_q    <= '0;
      abs_b_q    <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      a_raw_q    <= a_raw_d;
      abs_b_q    <= abs_b_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      b_zero_q   <= b_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      q_q        <= q_d;
      r_q        <= r_d;
`ifdef DIV_ZERO_DETECT_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.q        = q_q;
  assign bus.r        = r_q;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed divides queue expectations, a
// negedge monitor checks each done pulse (q, r, latency, div_zero).
module tb_div_seq;

  localparam int W = 32;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZD_EN = 1'b1;
`else
  localparam bit ZD_EN = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int         lat;
    bit         dz;
    int         issue_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  exp_t sb[$];

  div_seq_if #(.DATA_WIDTH(W)) bus ();

  div_seq #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.busy && bus.done) begin
        errors++;
        $display("FAIL busy_done_overlap busy=%0b done=%0b required not both high", bus.busy, bus.done);
      end
      if (bus.done === 1'b1) begin
        exp_t e;
        bit   dz_got;
        done_seen++;
`ifdef DIV_ZERO_DETECT_EN
        dz_got = bus.div_zero;
`else
        dz_got = 1'b0;
`endif
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done q=%h r=%h required no done", bus.q, bus.r);
        end else begin
          e = sb.pop_front();
          $display("txn %s: q=%h r=%h lat=%0d dz=%0b", e.name, bus.q, bus.r, cyc - e.issue_cyc, dz_got);
          if (bus.q !== e.q) begin
            errors++;
            $display("FAIL %s_q got %h required %h", e.name, bus.q, e.q);
          end
          checks++;
          if (bus.r !== e.r) begin
            errors++;
            $display("FAIL %s_r got %h required %h", e.name, bus.r, e.r);
          end
          checks++;
          if ((cyc - e.issue_cyc) != e.lat) begin
            errors++;
            $display("FAIL %s_latency got %0d required %0d", e.name, cyc - e.issue_cyc, e.lat);
          end
          checks++;
          if (dz_got !== e.dz) begin
            errors++;
            $display("FAIL %s_div_zero got %0b required %0b", e.name, dz_got, e.dz);
          end
        end
      end
    end
  end

  // Caller is just after a negedge; start is held for one edge.
  task automatic issue(input string name, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                       input bit s_v, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input bit push, output int snap);
    exp_t e;
    bit   zd;
    zd        = (b_v == '0) && ZD_EN;
    bus.a     = a_v;
    bus.b     = b_v;
    bus.sign  = s_v;
    bus.start = 1'b1;
    snap      = done_seen;
    if (push) begin
      e.name      = name;
      e.q         = eq;
      e.r         = er;
      e.lat       = zd ? 1 : 33;
      e.dz        = zd;
      e.issue_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== !zd) begin
      errors++;
      $display("FAIL %s_busy_after_start got %0b required %0b", name, bus.busy, !zd);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int snap);
    int n;
    n = 0;
    while (done_seen == snap && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (done_seen == snap) begin
      errors++;
      $display("FAIL %s_timeout got no done required done within 100 cycles", name);
    end
  endtask

  task automatic run(input string name, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                     input bit s_v, input logic [W-1:0] eq, input logic [W-1:0] er);
    int snap;
    @(negedge clk);
    issue(name, a_v, b_v, s_v, eq, er, 1'b1, snap);
    wait_done(name, snap);
  endtask

  initial begin
    int snap;
    int n;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    #1;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b required 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b required 0", bus.done); end
    if (bus.q !== '0) begin errors++; $display("FAIL reset_q got %h required 0", bus.q); end
    if (bus.r !== '0) begin errors++; $display("FAIL reset_r got %h required 0", bus.r); end
    @(negedge clk);
    rst = 1'b0;

    run("u_100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2);
    run("s_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
    run("s_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1);
    run("s_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0);
    run("u_big",      32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000);
    run("u_div0",     32'd123,        32'd0,          1'b0, 32'hFFFF_FFFF,  32'd123);
    run("s_div0_neg", 32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB);
    run("s_m100_7",   32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE);

    // Back-to-back: second start is held in the DONE cycle of the first.
    @(negedge clk);
    issue("b2b_9_4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b1, snap);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (bus.done !== 1'b1 && n < 100);
    issue("b2b_50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b1, snap);
    wait_done("b2b_50_5", snap);

    // Start pulse and operand churn during CALC must not disturb the result.
    @(negedge clk);
    issue("ign_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1, snap);
    repeat (3) @(negedge clk);
    #1;
    checks += 2;
    if (bus.q !== 32'd10) begin errors++; $display("FAIL hold_q got %h required %h", bus.q, 32'd10); end
    if (bus.r !== 32'd0) begin errors++; $display("FAIL hold_r got %h required %h", bus.r, 32'd0); end
    bus.start = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    bus.sign  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.a = ~bus.a;
      bus.b = bus.b + 32'd3;
      @(negedge clk);
    end
    wait_done("ign_100_7", snap);

    // Asynchronous reset in the middle of a CALC.
    @(negedge clk);
    issue("rst_victim", 32'd100, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, snap);
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b required 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b required 0", bus.done); end
    if (bus.q !== '0) begin errors++; $display("FAIL midrst_q got %h required 0", bus.q); end
    if (bus.r !== '0) begin errors++; $display("FAIL midrst_r got %h required 0", bus.r); end
    @(negedge clk);
    rst = 1'b0;
    run("post_rst_9_4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1);

    repeat (40) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
